// File: rtl/launcher_pkg.sv
// rtl/launcher_pkg.sv - shared state encoding and default constants for core_launcher
package launcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        START,
        RUN,
        REPORT
    } launcher_state_t;

    localparam int DEF_CYC_W      = 16;
    localparam int DEF_TIMEOUT    = 16'hFFFF;
    localparam int DEF_START_HOLD = 2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at LIMIT
module sat_counter #(
    parameter int           W     = 8,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/core_launcher.sv
// rtl/core_launcher.sv - resets the core and launches each program via start/done, reporting cycle counts
// Optional total_cycles accumulator: define CORE_LAUNCHER_TOTAL_EN.
module core_launcher
    import launcher_pkg::*;
#(
    parameter int  NUM_PROGS  = 3,
    parameter int  CYC_W      = DEF_CYC_W,
    parameter int  TIMEOUT    = DEF_TIMEOUT,
    parameter int  START_HOLD = DEF_START_HOLD,
    localparam int PID_W      = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
    localparam int TOT_W      = CYC_W + PID_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             abort,
    output logic             run_busy,
    output logic             core_reset,
    output logic             core_start,
    input  logic             core_done,
    output logic [PID_W-1:0] prog_id,
    output logic             result_valid,
    output logic [PID_W-1:0] result_prog,
    output logic [CYC_W-1:0] result_cycles,
    output logic             result_timeout,
    output logic             seq_done,
    output logic [TOT_W-1:0] total_cycles
);

    localparam int                HOLD_W    = $clog2(START_HOLD + 1);
    localparam logic [PID_W-1:0]  LAST_PID  = PID_W'(NUM_PROGS - 1);
    localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_C    = HOLD_W'(START_HOLD);

    launcher_state_t  state_q, state_d;
    logic [PID_W-1:0] prog_id_q, prog_id_d;
    logic [CYC_W-1:0] run_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic             run_en, hold_en, timed_out;

    logic             run_busy_q, run_busy_d;
    logic             core_reset_q, core_reset_d;
    logic             core_start_q, core_start_d;
    logic             result_valid_q, result_valid_d;
    logic [PID_W-1:0] result_prog_q, result_prog_d;
    logic [CYC_W-1:0] result_cycles_q, result_cycles_d;
    logic             result_timeout_q, result_timeout_d;
    logic             seq_done_q, seq_done_d;

    // Counters run off state_d so the first cycle spent in a state already reads 1.
    assign run_en  = (state_d == RUN);
    assign hold_en = (state_d == START);

    sat_counter #(.W(CYC_W), .LIMIT(TIMEOUT_C)) u_run_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (!run_en),
        .en    (run_en),
        .count (run_cnt)
    );

    sat_counter #(.W(HOLD_W), .LIMIT(HOLD_C)) u_hold_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (!hold_en),
        .en    (hold_en),
        .count (hold_cnt)
    );

    assign timed_out = (run_cnt == TIMEOUT_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            prog_id_q        <= '0;
            run_busy_q       <= 1'b0;
            core_reset_q     <= 1'b0;
            core_start_q     <= 1'b0;
            result_valid_q   <= 1'b0;
            result_prog_q    <= '0;
            result_cycles_q  <= '0;
            result_timeout_q <= 1'b0;
            seq_done_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            prog_id_q        <= prog_id_d;
            run_busy_q       <= run_busy_d;
            core_reset_q     <= core_reset_d;
            core_start_q     <= core_start_d;
            result_valid_q   <= result_valid_d;
            result_prog_q    <= result_prog_d;
            result_cycles_q  <= result_cycles_d;
            result_timeout_q <= result_timeout_d;
            seq_done_q       <= seq_done_d;
        end
    end

    // Abort wins over done and timeout; done is not looked at until RUN.
    always_comb begin
        state_d   = state_q;
        prog_id_d = prog_id_q;
        if ((state_q != IDLE) && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_req) begin
                        state_d   = CRST;
                        prog_id_d = '0;
                    end
                end
                CRST:  state_d = START;
                START: if (hold_cnt == HOLD_C) state_d = RUN;
                RUN:   if (core_done || timed_out) state_d = REPORT;
                REPORT: begin
                    if (prog_id_q == LAST_PID) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = CRST;
                        prog_id_d = prog_id_q + PID_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        run_busy_d       = (state_d != IDLE);
        core_reset_d     = (state_d == CRST);
        core_start_d     = (state_d == START);
        result_valid_d   = (state_d == REPORT);
        seq_done_d       = (state_d == REPORT) && (prog_id_q == LAST_PID);
        result_prog_d    = result_prog_q;
        result_cycles_d  = result_cycles_q;
        result_timeout_d = result_timeout_q;
        if (state_d == REPORT) begin
            result_prog_d    = prog_id_q;
            result_cycles_d  = run_cnt;
            result_timeout_d = timed_out && !core_done;
        end
    end

`ifdef CORE_LAUNCHER_TOTAL_EN
    logic [TOT_W-1:0] total_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else if ((state_q == IDLE) && run_req) begin
            total_q <= '0;
        end else if (state_d == REPORT) begin
            total_q <= total_q + TOT_W'(run_cnt);
        end
    end

    assign total_cycles = total_q;
`else
    assign total_cycles = '0;
`endif

    assign run_busy       = run_busy_q;
    assign core_reset     = core_reset_q;
    assign core_start     = core_start_q;
    assign prog_id        = prog_id_q;
    assign result_valid   = result_valid_q;
    assign result_prog    = result_prog_q;
    assign result_cycles  = result_cycles_q;
    assign result_timeout = result_timeout_q;
    assign seq_done       = seq_done_q;

endmodule

// File: tb/tb_core_launcher.sv
// tb/tb_core_launcher.sv - scoreboard bench for core_launcher with long- and short-timeout instances
module tb_core_launcher;

    localparam int NP       = 3;
    localparam int PW       = 2;
    localparam int CW       = 16;
    localparam int TW       = CW + PW + 1;
    localparam int TO_SHORT = 8;

    typedef struct {
        int dut;
        int prog;
        int cyc;
        int to;
        int last;
        int tot;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic rst_n;

    logic          run_req   [2];
    logic          abort_in  [2];
    logic          core_done [2];
    logic          busy      [2];
    logic          crst      [2];
    logic          cstart    [2];
    logic          rv        [2];
    logic          rto       [2];
    logic          sdone     [2];
    logic [PW-1:0] pid       [2];
    logic [PW-1:0] rprog     [2];
    logic [CW-1:0] rcyc      [2];
    logic [TW-1:0] tot       [2];

    int delay_tab  [2][NP];
    bit force_done [2];
    int to_lim     [2] = '{32'hFFFF, TO_SHORT};

    always #5 clk = ~clk;

    core_launcher #(.NUM_PROGS(NP), .CYC_W(CW), .TIMEOUT(16'hFFFF), .START_HOLD(2)) u_long (
        .clk(clk), .reset(rst_n), .run_req(run_req[0]), .abort(abort_in[0]),
        .run_busy(busy[0]), .core_reset(crst[0]), .core_start(cstart[0]), .core_done(core_done[0]),
        .prog_id(pid[0]), .result_valid(rv[0]), .result_prog(rprog[0]), .result_cycles(rcyc[0]),
        .result_timeout(rto[0]), .seq_done(sdone[0]), .total_cycles(tot[0])
    );

    core_launcher #(.NUM_PROGS(NP), .CYC_W(CW), .TIMEOUT(TO_SHORT), .START_HOLD(2)) u_short (
        .clk(clk), .reset(rst_n), .run_req(run_req[1]), .abort(abort_in[1]),
        .run_busy(busy[1]), .core_reset(crst[1]), .core_start(cstart[1]), .core_done(core_done[1]),
        .prog_id(pid[1]), .result_valid(rv[1]), .result_prog(rprog[1]), .result_cycles(rcyc[1]),
        .result_timeout(rto[1]), .seq_done(sdone[1]), .total_cycles(tot[1])
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Core model: done rises delay_tab RUN cycles after start falls (-1 = never).
    int run_cnt [2];
    bit armed   [2];
    initial begin : core_model
        bit md;
        for (int i = 0; i < 2; i++) begin
            core_done[i] = 1'b0;
            armed[i]     = 1'b0;
            run_cnt[i]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                md = 1'b0;
                if (busy[i] !== 1'b1 || crst[i] === 1'b1) begin
                    armed[i] = 1'b0;
                end else if (cstart[i] === 1'b1) begin
                    armed[i]   = 1'b1;
                    run_cnt[i] = 0;
                end else if (armed[i]) begin
                    run_cnt[i]++;
                    if (run_cnt[i] == delay_tab[i][pid[i]]) begin
                        md       = 1'b1;
                        armed[i] = 1'b0;
                    end
                end
                core_done[i] = md | force_done[i];
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rv[i] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 64'(rv[i]), 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("res_dut", i, e.dut);
                        check("res_prog", rprog[i], e.prog);
                        check("res_cycles", rcyc[i], e.cyc);
                        check("res_timeout", rto[i], e.to);
                        check("res_seq_done", sdone[i], e.last);
                        if (e.last != 0) check("total_cycles", tot[i], e.tot);
                    end
                end
            end
        end
    end

    task automatic push_seq(input int i);
        exp_t e;
        int   sum = 0;
        for (int p = 0; p < NP; p++) begin
            int d = delay_tab[i][p];
            if (force_done[i]) begin
                e.cyc = 1;
                e.to  = 0;
            end else if (d < 1 || d > to_lim[i]) begin
                e.cyc = to_lim[i];
                e.to  = 1;
            end else begin
                e.cyc = d;
                e.to  = 0;
            end
            sum += e.cyc;
            e.dut  = i;
            e.prog = p;
            e.last = (p == NP - 1) ? 1 : 0;
`ifdef CORE_LAUNCHER_TOTAL_EN
            e.tot = sum;
`else
            e.tot = 0;
`endif
            sb_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic launch(input int i);
        push_seq(i);
        run_req[i] = 1'b1;
        @(negedge clk);
        check("launch_busy", busy[i], 1);
        check("launch_core_reset", crst[i], 1);
        check("launch_prog_id", pid[i], 0);
        check("launch_start_low", cstart[i], 0);
        run_req[i] = 1'b0;
        @(negedge clk);
        check("start_hold1", cstart[i], 1);
        check("core_reset_one_cycle", crst[i], 0);
        @(negedge clk);
        check("start_hold2", cstart[i], 1);
        @(negedge clk);
        check("start_drop", cstart[i], 0);
    endtask

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (busy[i] === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("seq_finished", busy[i], 0);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic check_zero(input int i);
        check("rst_busy", busy[i], 0);
        check("rst_core_reset", crst[i], 0);
        check("rst_core_start", cstart[i], 0);
        check("rst_prog_id", pid[i], 0);
        check("rst_result_valid", rv[i], 0);
        check("rst_result_prog", rprog[i], 0);
        check("rst_result_cycles", rcyc[i], 0);
        check("rst_result_timeout", rto[i], 0);
        check("rst_seq_done", sdone[i], 0);
        check("rst_total_cycles", tot[i], 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin : main
        int n;
        int idle;
        for (int i = 0; i < 2; i++) begin
            run_req[i]    = 1'b0;
            abort_in[i]   = 1'b0;
            force_done[i] = 1'b0;
            delay_tab[i]  = '{1, 1, 1};
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) check_zero(i);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic run on the long-timeout instance
        delay_tab[0] = '{5, 9, 1};
        launch(0);
        wait_idle(0, 200);

        // Program 1 never finishes: timeout at 8, program 2 still runs
        delay_tab[1] = '{4, -1, 3};
        launch(1);
        wait_idle(1, 200);
        repeat (3) @(negedge clk);
        check("hold_result_cycles", rcyc[1], 3);
        check("hold_result_prog", rprog[1], 2);
        check("valid_single_pulse", rv[1], 0);

        // Stale done held high the whole sequence
        force_done[1] = 1'b1;
        @(negedge clk);
        launch(1);
        wait_idle(1, 200);
        force_done[1] = 1'b0;
        @(negedge clk);

        // Abort in the same cycle as done of program 1
        delay_tab[1] = '{2, 3, 2};
        launch(1);
        n = 0;
        while (!(pid[1] === 1 && cstart[1] === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_prog1", pid[1], 1);
        while (cstart[1] === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        abort_in[1] = 1'b1;
        sb_q.delete();
        @(negedge clk);
        abort_in[1] = 1'b0;
        check("abort_busy", busy[1], 0);
        check("abort_core_start", cstart[1], 0);
        check("abort_core_reset", crst[1], 0);
        check("abort_no_valid", rv[1], 0);
        check("abort_no_seq_done", sdone[1], 0);
        repeat (2) @(negedge clk);
        check("abort_stays_idle", busy[1], 0);
        delay_tab[1] = '{1, 2, 3};
        launch(1);
        wait_idle(1, 200);

        // Asynchronous reset in the middle of RUN
        delay_tab[1] = '{-1, -1, -1};
        launch(1);
        repeat (3) @(negedge clk);
        #2;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero(1);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", busy[1], 0);
        check("post_reset_no_core_reset", crst[1], 0);

        // run_req held high: ignored mid-sequence, then exactly one IDLE cycle
        delay_tab[1] = '{2, 3, 1};
        push_seq(1);
        push_seq(1);
        run_req[1] = 1'b1;
        n = 0;
        while (sdone[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("first_seq_done", sdone[1], 1);
        idle = 0;
        n    = 0;
        @(negedge clk);
        while (busy[1] !== 1'b1 && n < 10) begin
            idle++;
            n++;
            @(negedge clk);
        end
        check("idle_gap", idle, 1);
        check("restart_prog_id", pid[1], 0);
        check("restart_core_reset", crst[1], 1);
        run_req[1] = 1'b0;
        wait_idle(1, 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
